// File: rtl/mmio_io_hub.sv
// mmio_io_hub: memory-mapped IO hub for the MEM stage.
// Status register, RX/TX byte FIFOs facing an external uart core,
// cycle and retired-instruction counters, sticky error flags.
// Optional interrupt logic and mask register at 0x07 are built when the
// macro MMIO_IO_HUB_IRQ_EN is defined.
module mmio_io_hub #(
  parameter int XLEN     = 32,
  parameter int ADR_W    = 5,
  parameter int RX_DEPTH = 8,
  parameter int TX_DEPTH = 8,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             cpu_rst_n,
  input  logic             io_en,
  input  logic [3:0]       wea,
  input  logic [ADR_W-1:0] adr,
  input  logic [XLEN-1:0]  din_io,
  output logic [XLEN-1:0]  dout_io,
  input  logic             instr_retire,
  output logic [7:0]       uart_tx_data,
  output logic             uart_tx_valid,
  input  logic             uart_tx_ready,
  input  logic [7:0]       uart_rx_data,
  input  logic             uart_rx_valid,
  output logic             uart_rx_ready
`ifdef MMIO_IO_HUB_IRQ_EN
  ,
  output logic             io_irq
`endif
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);

  localparam logic [ADR_W-1:0] A_STATUS = 'd0;
  localparam logic [ADR_W-1:0] A_RXDATA = 'd1;
  localparam logic [ADR_W-1:0] A_TXDATA = 'd2;
  localparam logic [ADR_W-1:0] A_COUNT  = 'd3;
  localparam logic [ADR_W-1:0] A_CYCLE  = 'd4;
  localparam logic [ADR_W-1:0] A_INSTR  = 'd5;
  localparam logic [ADR_W-1:0] A_CLRCNT = 'd6;
`ifdef MMIO_IO_HUB_IRQ_EN
  localparam logic [ADR_W-1:0] A_MASK   = 'd7;
`endif

  // FIFO storage (no reset: contents are don't-care once pointers flush)
  logic [7:0] rx_mem [RX_DEPTH];
  logic [7:0] tx_mem [TX_DEPTH];

  // state flops
  logic [RX_AW:0]    rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [TX_AW:0]    tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [XLEN-1:0]   dout_q, dout_d;
  logic              rx_ready_q, rx_ready_d;
  logic              tx_ovf_q, tx_ovf_d;
  logic              rx_empty_rd_q, rx_empty_rd_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]  instr_cnt_q, instr_cnt_d;
`ifdef MMIO_IO_HUB_IRQ_EN
  logic [2:0]        irq_mask_q, irq_mask_d;
  logic              irq_q, irq_d;
`endif

  // decode and FIFO status
  logic             rd, wr;
  logic             rx_empty, rx_full, tx_empty, tx_full;
  logic             rx_push, rx_pop, tx_push, tx_pop, tx_drop;
  logic             rx_full_nx;
  logic [XLEN-1:0]  rdata;
  logic             unused_din;

  assign unused_din = ^din_io[XLEN-1:8];

  assign rd = io_en & (wea == 4'd0);
  assign wr = io_en & (wea != 4'd0);

  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[RX_AW] != rx_rd_q[RX_AW]) &&
                    (rx_wr_q[RX_AW-1:0] == rx_rd_q[RX_AW-1:0]);
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[TX_AW] != tx_rd_q[TX_AW]) &&
                    (tx_wr_q[TX_AW-1:0] == tx_rd_q[TX_AW-1:0]);

  // Ready is a registered copy of !full, so pushes never see a full FIFO.
  assign rx_push = uart_rx_valid & rx_ready_q & ~rx_full;
  assign rx_pop  = rd & (adr == A_RXDATA) & ~rx_empty;
  assign tx_push = wr & (adr == A_TXDATA) & ~tx_full;
  assign tx_drop = wr & (adr == A_TXDATA) & tx_full;
  assign tx_pop  = ~tx_empty & uart_tx_ready;

  assign uart_tx_valid = ~tx_empty;
  assign uart_tx_data  = tx_mem[tx_rd_q[TX_AW-1:0]];
  assign uart_rx_ready = rx_ready_q;
  assign dout_io       = dout_q;
`ifdef MMIO_IO_HUB_IRQ_EN
  assign io_irq        = irq_q;
`endif

  // read-data mux for the addressed register (values as of this cycle)
  always_comb begin
    rdata = '0;
    case (adr)
      A_STATUS: rdata[4:0] = {tx_ovf_q, rx_empty_rd_q, rx_full, ~rx_empty, ~tx_full};
      A_RXDATA: if (!rx_empty) rdata[7:0] = rx_mem[rx_rd_q[RX_AW-1:0]];
      A_COUNT: begin
        rdata[16 +: RX_AW+1] = rx_wr_q - rx_rd_q;
        rdata[0  +: TX_AW+1] = tx_wr_q - tx_rd_q;
      end
      A_CYCLE:  rdata = XLEN'(cycle_cnt_q);
      A_INSTR:  rdata = XLEN'(instr_cnt_q);
`ifdef MMIO_IO_HUB_IRQ_EN
      A_MASK:   rdata[2:0] = irq_mask_q;
`endif
      default:  rdata = '0;
    endcase
  end

  // next-state computation for all flops
  always_comb begin
    rx_wr_d = rx_wr_q + (RX_AW+1)'(rx_push);
    rx_rd_d = rx_rd_q + (RX_AW+1)'(rx_pop);
    tx_wr_d = tx_wr_q + (TX_AW+1)'(tx_push);
    tx_rd_d = tx_rd_q + (TX_AW+1)'(tx_pop);

    rx_full_nx = (rx_wr_d[RX_AW] != rx_rd_d[RX_AW]) &&
                 (rx_wr_d[RX_AW-1:0] == rx_rd_d[RX_AW-1:0]);
    rx_ready_d = ~rx_full_nx;

    dout_d = rd ? rdata : dout_q;

    // clearing write and flag-setting events never share a cycle
    tx_ovf_d      = tx_ovf_q;
    rx_empty_rd_d = rx_empty_rd_q;
    if (wr && adr == A_STATUS) begin
      tx_ovf_d      = 1'b0;
      rx_empty_rd_d = 1'b0;
    end
    if (tx_drop) tx_ovf_d = 1'b1;
    if (rd && adr == A_RXDATA && rx_empty) rx_empty_rd_d = 1'b1;

    // clear wins over the same-cycle increment
    if (wr && adr == A_CLRCNT) begin
      cycle_cnt_d = '0;
      instr_cnt_d = '0;
    end else begin
      cycle_cnt_d = cycle_cnt_q + 1'b1;
      instr_cnt_d = instr_cnt_q + CNT_W'(instr_retire);
    end

`ifdef MMIO_IO_HUB_IRQ_EN
    irq_mask_d = (wr && adr == A_MASK) ? din_io[2:0] : irq_mask_q;
    irq_d = |(irq_mask_q & {tx_ovf_q | rx_empty_rd_q, tx_empty, ~rx_empty});
`endif
  end

  // state registers with asynchronous flush
  always_ff @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      rx_wr_q       <= '0;
      rx_rd_q       <= '0;
      tx_wr_q       <= '0;
      tx_rd_q       <= '0;
      dout_q        <= '0;
      rx_ready_q    <= 1'b0;
      tx_ovf_q      <= 1'b0;
      rx_empty_rd_q <= 1'b0;
      cycle_cnt_q   <= '0;
      instr_cnt_q   <= '0;
`ifdef MMIO_IO_HUB_IRQ_EN
      irq_mask_q    <= '0;
      irq_q         <= 1'b0;
`endif
    end else begin
      rx_wr_q       <= rx_wr_d;
      rx_rd_q       <= rx_rd_d;
      tx_wr_q       <= tx_wr_d;
      tx_rd_q       <= tx_rd_d;
      dout_q        <= dout_d;
      rx_ready_q    <= rx_ready_d;
      tx_ovf_q      <= tx_ovf_d;
      rx_empty_rd_q <= rx_empty_rd_d;
      cycle_cnt_q   <= cycle_cnt_d;
      instr_cnt_q   <= instr_cnt_d;
`ifdef MMIO_IO_HUB_IRQ_EN
      irq_mask_q    <= irq_mask_d;
      irq_q         <= irq_d;
`endif
    end
  end

  // FIFO storage writes
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_q[RX_AW-1:0]] <= uart_rx_data;
    if (tx_push) tx_mem[tx_wr_q[TX_AW-1:0]] <= din_io[7:0];
  end

endmodule

// File: tb/tb_mmio_io_hub.sv
// Scoreboard bench for mmio_io_hub: reads and TX bytes push expected
// values into queues; monitors pop and compare when the DUT presents data.
module tb_mmio_io_hub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        io_en = 1'b0;
  logic [3:0]  wea = 4'd0;
  logic [4:0]  adr = 5'd0;
  logic [31:0] din_io = 32'd0;
  logic [31:0] dout_io;
  logic        instr_retire = 1'b0;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready = 1'b0;
  logic [7:0]  uart_rx_data = 8'd0;
  logic        uart_rx_valid = 1'b0;
  logic        uart_rx_ready;
`ifdef MMIO_IO_HUB_IRQ_EN
  logic        io_irq;
  logic        w_irq;
`endif

  // narrow-counter instance used only to observe wrap-around
  logic [31:0] w_dout;
  logic [7:0]  w_tx_data;
  logic        w_tx_valid, w_rx_ready;
  logic        w_tx_ready = 1'b0;
  logic [7:0]  w_rx_data = 8'd0;
  logic        w_rx_valid = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];
  logic [7:0]  tx_exp_q[$];
  logic        rd_seen = 1'b0;

  always #5 clk = ~clk;

  mmio_io_hub u_dut (
    .clk(clk), .cpu_rst_n(rst_n), .io_en(io_en), .wea(wea), .adr(adr),
    .din_io(din_io), .dout_io(dout_io), .instr_retire(instr_retire),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid),
    .uart_tx_ready(uart_tx_ready), .uart_rx_data(uart_rx_data),
    .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready)
`ifdef MMIO_IO_HUB_IRQ_EN
    , .io_irq(io_irq)
`endif
  );

  mmio_io_hub #(.CNT_W(8)) u_wrap (
    .clk(clk), .cpu_rst_n(rst_n), .io_en(io_en), .wea(wea), .adr(adr),
    .din_io(din_io), .dout_io(w_dout), .instr_retire(instr_retire),
    .uart_tx_data(w_tx_data), .uart_tx_valid(w_tx_valid),
    .uart_tx_ready(w_tx_ready), .uart_rx_data(w_rx_data),
    .uart_rx_valid(w_rx_valid), .uart_rx_ready(w_rx_ready)
`ifdef MMIO_IO_HUB_IRQ_EN
    , .io_irq(w_irq)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // note which edges captured a read; dout_io is valid after that edge
  always @(posedge clk) rd_seen <= rst_n && io_en && (wea == 4'd0);

  // read monitor
  always @(negedge clk) begin
    if (rd_seen) begin
      if (rd_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected: got 0x%08h expected none", dout_io);
      end else begin
        check(rd_name_q.pop_front(), dout_io, rd_exp_q.pop_front());
      end
    end
  end

  // TX handshake monitor
  always @(negedge clk) begin
    if (rst_n && uart_tx_valid && uart_tx_ready) begin
      if (tx_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL tx_unexpected: got 0x%02h expected none", uart_tx_data);
      end else begin
        check("tx_byte", {24'd0, uart_tx_data}, {24'd0, tx_exp_q.pop_front()});
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(name);
    io_en = 1'b1; wea = 4'd0; adr = a;
    cyc();
    io_en = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    io_en = 1'b1; wea = 4'hF; adr = a; din_io = d;
    cyc();
    io_en = 1'b0; wea = 4'd0;
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // reset
    repeat (3) cyc();
    check("rst_tx_valid", {31'd0, uart_tx_valid}, 32'd0);
    check("rst_rx_ready", {31'd0, uart_rx_ready}, 32'd0);
    check("rst_dout", dout_io, 32'd0);
`ifdef MMIO_IO_HUB_IRQ_EN
    check("rst_irq", {31'd0, io_irq}, 32'd0);
`endif
    rst_n = 1'b1;
    cyc();
    check("rx_ready_after_rst", {31'd0, uart_rx_ready}, 32'd1);
    rd(5'd0, 32'h0000_0001, "status_reset");

    // TX basic
    for (int i = 0; i < 3; i++) wr(5'd2, 32'h41 + i);
    rd(5'd3, 32'h0000_0003, "tx_count3");
    tx_exp_q.push_back(8'h41); tx_exp_q.push_back(8'h42); tx_exp_q.push_back(8'h43);
    uart_tx_ready = 1'b1;
    repeat (4) cyc();
    check("tx_drained_valid", {31'd0, uart_tx_valid}, 32'd0);
    uart_tx_ready = 1'b0;

    // TX overflow
    for (int i = 0; i < 9; i++) wr(5'd2, 32'h50 + i);
    rd(5'd0, 32'h0000_0010, "status_tx_ovf");
    rd(5'd3, 32'h0000_0008, "tx_count8");
    wr(5'd0, 32'd0);
    rd(5'd0, 32'h0000_0000, "status_ovf_clr");
    for (int i = 0; i < 8; i++) tx_exp_q.push_back(8'(8'h50 + i));
    uart_tx_ready = 1'b1;
    repeat (9) cyc();
    uart_tx_ready = 1'b0;
    check("tx_empty_valid", {31'd0, uart_tx_valid}, 32'd0);
    rd(5'd0, 32'h0000_0001, "status_tx_empty");

    // RX fill
    uart_rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      uart_rx_data = 8'(8'h10 + i);
      cyc();
    end
    uart_rx_valid = 1'b0;
    check("rx_full_ready", {31'd0, uart_rx_ready}, 32'd0);
    rd(5'd0, 32'h0000_0007, "status_rx_full");
    rd(5'd3, 32'h0008_0000, "rx_count8");
    for (int i = 0; i < 8; i++) rd(5'd1, 32'h10 + i, "rx_data");
    rd(5'd1, 32'h0000_0000, "rx_empty_read");
    rd(5'd0, 32'h0000_0009, "status_rx_empty_rd");
    check("rx_ready_again", {31'd0, uart_rx_ready}, 32'd1);
    wr(5'd0, 32'd0);
    rd(5'd0, 32'h0000_0001, "status_sticky_clr");

    // counters: clear beats same-cycle retire
    instr_retire = 1'b1;
    wr(5'd6, 32'd0);
    instr_retire = 1'b0;
    rd(5'd4, 32'd0, "cycle_after_clr");
    rd(5'd5, 32'd0, "instr_after_clr");
    wr(5'd6, 32'd0);
    for (int i = 0; i < 100; i++) begin
      instr_retire = (i < 40);
      cyc();
    end
    instr_retire = 1'b0;
    rd(5'd4, 32'd100, "cycle_100");
    rd(5'd5, 32'd40, "instr_40");

    // wrap on the 8-bit counter instance
    wr(5'd6, 32'd0);
    repeat (255) cyc();
    rd(5'd4, 32'd255, "cycle_255");
    check("wrap_max", w_dout, 32'h0000_00FF);
    rd(5'd4, 32'd256, "cycle_256");
    check("wrap_zero", w_dout, 32'h0000_0000);

`ifdef MMIO_IO_HUB_IRQ_EN
    wr(5'd7, 32'd1);
    rd(5'd7, 32'd1, "irq_mask");
    uart_rx_data = 8'h99; uart_rx_valid = 1'b1;
    cyc();
    uart_rx_valid = 1'b0;
    check("irq_at_push", {31'd0, io_irq}, 32'd0);
    cyc();
    check("irq_after_push", {31'd0, io_irq}, 32'd1);
    rd(5'd1, 32'h99, "irq_rx_data");
    check("irq_at_pop", {31'd0, io_irq}, 32'd1);
    cyc();
    check("irq_after_pop", {31'd0, io_irq}, 32'd0);
`endif

    repeat (2) cyc();
    check("rd_queue_empty", rd_exp_q.size(), 32'd0);
    check("tx_queue_empty", tx_exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_io_hub.md
Name: mmio_io_hub

Overview:
- Parametrised successor to the core's memory-mapped IO controller.
- Decodes word-addressed IO accesses from the MEM stage and provides a status register, RX and TX byte FIFOs in front of an external uart core, a cycle counter and a retired-instruction counter.
- Reads are registered, giving a 1-cycle read latency.
- Adds sticky error flags, FIFO occupancy readback and an optional interrupt.

Parameters:
- XLEN, 32: data bus width.
- ADR_W, 5: IO word-address width.
- RX_DEPTH, 8: RX FIFO entries; power of two, ≥2.
- TX_DEPTH, 8: TX FIFO entries; power of two, ≥2.
- CNT_W, 32: counter width, ≤ XLEN; zero-extended on read.

Ports:
- clk  in  1  core clock.
- cpu_rst_n  in  1  reset: asynchronous, active-low.
- io_en  in  1  IO access this cycle.
- wea  in  4  byte write enables; nonzero = write, zero = read.
- adr  in  ADR_W  IO word address.
- din_io  in  XLEN  write data.
- dout_io  out  XLEN  registered read data.
- instr_retire  in  1  one instruction retired this cycle.
- uart_tx_data  out  8  byte to uart transmitter.
- uart_tx_valid  out  1  TX FIFO not empty.
- uart_tx_ready  in  1  transmitter accepts byte.
- uart_rx_data  in  8  byte from uart receiver.
- uart_rx_valid  in  1  receiver byte available.
- uart_rx_ready  out  1  RX FIFO not full.
- io_irq  out  1  interrupt; present only with MMIO_IO_HUB_IRQ_EN.

Behaviour:
- Reset: all of the following are 0; counters cleared; sticky flags cleared.
  - dout_io, uart_tx_valid, uart_rx_ready (rises 1 cycle after release), io_irq.
  - All FIFO pointers.
- Access decode:
  - rd = io_en & (wea==0); wr = io_en & (wea!=0).
  - dout_io updates only on rd; otherwise it holds.
  - Unmapped read returns 0; unmapped write is ignored.
- 0x00 read, status: {XLEN-5 zeros, tx_ovf, rx_empty_rd, rx_full, rx_nonempty, tx_notfull}, bits [4:0].
  - tx_ovf and rx_empty_rd are sticky.
  - Write to 0x00 clears both sticky flags.
- 0x01 read: returns the RX FIFO head zero-extended and pops it.
  - If the RX FIFO is empty: returns 0, no pop, sets rx_empty_rd.
- 0x02 write: pushes din_io[7:0] into the TX FIFO.
  - If the TX FIFO is full: byte dropped, sets tx_ovf.
- 0x03 read: {rx_count at [23:16], tx_count at [7:0]}; each count is log2(DEPTH)+1 bits wide.
- 0x04 read: cycle_cnt. 0x05 read: instr_cnt. Both values are as of the access cycle, before that cycle's increment.
- 0x06 write: clears both counters; they are 0 in the following cycle. Clear wins over a same-cycle increment.
- Counters:
  - cycle_cnt increments every cycle.
  - instr_cnt increments when instr_retire=1.
  - Both wrap modulo 2^CNT_W.
- TX side:
  - uart_tx_data = head entry (combinational from FIFO storage); uart_tx_valid = !tx_empty.
  - Pop on uart_tx_valid & uart_tx_ready.
- RX side: uart_rx_ready = !rx_full (registered full flag); push on uart_rx_valid & uart_rx_ready.
- Simultaneous push and pop on the same FIFO:
  - When neither full nor empty, both occur and the count is unchanged.
  - When full, pop proceeds; the push is refused (RX) or dropped with tx_ovf (TX).
  - When empty, the push is accepted and the pop does nothing.
- FIFOs: pointers are log2(DEPTH)+1 bits and wrap naturally. full = MSBs differ and LSBs are equal; empty = pointers equal.
- Reset asserted mid-transfer: FIFOs flush and in-flight bytes are lost. uart_tx_valid drops asynchronously.

Optional Feature:
- Macro: MMIO_IO_HUB_IRQ_EN.
- Defined:
  - Adds register 0x07, irq_mask[2:0]: bit0 rx_nonempty, bit1 tx_empty, bit2 any sticky flag. Reset value 0.
  - Read of 0x07 returns the mask. Write loads din_io[2:0].
  - io_irq is registered: io_irq = |(mask & cond), updated each cycle, 1-cycle latency.
- Undefined: no io_irq port, no mask register; 0x07 is unmapped and reads 0.

Test Plan:
- Reset release, then read 0x00 -> dout_io=0x00000001 one cycle later (tx_notfull=1, RX empty).
- Write 0x41,0x42,0x43 to 0x02 with uart_tx_ready=0 -> read 0x03 gives tx_count=3. Then hold uart_tx_ready=1 -> uart_tx_data sequence 0x41,0x42,0x43, after which uart_tx_valid=0.
- With TX_DEPTH=8, write 9 bytes while uart_tx_ready=0 -> 9th byte dropped, status bit4=1. Write 0x00 -> bit4=0.
- Drive 8 RX bytes 0x10..0x17 -> uart_rx_ready=0 and status bit2=1. Nine reads of 0x01 -> 0x10..0x17 then 0, and status bit3=1.
- Write 0x06 in the same cycle as instr_retire=1 -> next cycle the counters are 0. Run 100 cycles with 40 retires, then read 0x04 and 0x05 -> 100 and 40. Preload cycle_cnt to 0xFFFFFFFF -> one cycle later it is 0.
- With MMIO_IO_HUB_IRQ_EN: write mask=1, push RX byte -> io_irq=1 one cycle after push. Read 0x01 -> io_irq=0 one cycle after the RX FIFO becomes empty.
